proc_ctrl: RTL
==============

# proc_ctrl

Multi-cycle control FSM for the 32-bit processor datapath. It sequences instruction fetch, decode, execute, memory access and register write-back. It drives every enable and mux select of the datapath (IR/MDR/MAR/PC enables, register-file write, ALU op, source selects) and the memory read/write strobes. It stalls on a memory ready handshake and halts on HALT or illegal opcodes.

## Interface
Parameters:
- none (instruction encoding fixed below)

Ports:
- iClk  input  1  clock; all state changes on rising edge
- nRst  input  1  reset, asynchronous and active-low; one clock; reset is asynchronous and active-low
- iIR  input  32  current instruction (IR output); opcode = [31:26], funct = [5:0]
- iALUZero  input  1  ALU zero flag, combinational from current ALU inputs
- iMemReady  input  1  memory completes current read/write this cycle
- oIR_en, oMDR_en, oMAR_en, oPC_en  output  1 each  register load enables
- oRF_Write  output  1  register-file write strobe
- oMAR_Select  output  1  0 = PC, 1 = ALU output register
- oALUsrcB_Select  output  1  0 = RB, 1 = sign-extended iIR[15:0]
- oPC_Select  output  2  00 = PC+4, 01 = branch target, 10 = jump target
- oRFC_Select  output  2  00 = ALU output register, 01 = MDR
- oALU_op  output  6  ALU function code
- oMemRead, oMemWrite  output  1 each  memory strobes
- oHalt  output  1  processor halted
- oIllegal  output  1  sticky; set when halted by an unknown opcode

## Operation
- Opcodes: 00 R-type (oALU_op = funct), 08 ADDI, 0C ANDI, 0D ORI, 23 LW, 2B SW, 04 BEQ, 05 BNE, 02 J, 3F HALT. All others are illegal.
- ALU codes: ADD 20, SUB 22, AND 24, OR 25. ADDI/LW/SW use ADD, ANDI uses AND, ORI uses OR, BEQ/BNE use SUB with ALUsrcB = 0.
- States and transitions:
  - RST -> FA
  - FA: MAR_Select = 0, MAR_en -> F
  - F: MemRead. While iMemReady = 0, stay in F. When iMemReady = 1: IR_en, PC_en with PC_Select 00 -> D
  - D: no enables asserted (RA/RB latch). HALT -> HLT. Illegal -> HLT and set oIllegal. Otherwise -> EX
  - EX: ALU_op and ALUsrcB driven per opcode; the ALU output register latches.
    - R-type and immediates -> WA
    - LW/SW -> MA
    - BEQ: PC_en = iALUZero, PC_Select 01 -> FA
    - BNE: PC_en = !iALUZero, PC_Select 01 -> FA
    - J: PC_en, PC_Select 10 -> FA
  - MA: MAR_Select = 1, MAR_en. LW -> MR, SW -> MW
  - MR: MemRead. Wait on iMemReady. When ready: MDR_en -> WM
  - MW: MemWrite. Wait on iMemReady. When ready -> FA
  - WA: RF_Write, RFC_Select 00 -> FA
  - WM: RF_Write, RFC_Select 01 -> FA
  - HLT: oHalt = 1; remain until reset.
- Outputs are decoded from state (Moore), except that the branch PC_en depends on iALUZero in EX. oALU_op holds its EX value in every state.
- In any state not listed for a signal, every enable, strobe and select is 0.

## Timing
- Reset (asynchronous): state RST. All outputs 0, including oHalt and oIllegal.
- RST lasts exactly 1 cycle after nRst deasserts.
- Latency with zero memory wait states:
  - R-type/immediate: 5 cycles (FA, F, D, EX, WA)
  - LW: 7 cycles
  - SW: 6 cycles
  - BEQ/BNE/J: 4 cycles
- Each cycle with iMemReady = 0 in F, MR or MW adds exactly one cycle. Strobes stay high and no enable fires until ready.
- iMemReady is ignored outside F, MR and MW.
- Reset mid-operation (any state, including a memory wait): immediately returns to RST and clears oIllegal.
- oMemRead and oMemWrite are never high in the same cycle.
- PC_en fires at most once per instruction outside F.

## Test plan
- ADD (iIR = 0x00221820), iMemReady = 1 → states FA,F,D,EX,WA; oALU_op = 0x20 in EX; oRF_Write high for exactly 1 cycle, in cycle 5.
- LW (opcode 23) with iMemReady low for 2 cycles in MR → MR lasts 3 cycles; oMDR_en only on the ready cycle; WM asserts oRF_Write with oRFC_Select = 01; total 9 cycles.
- BEQ with iALUZero = 1, then BNE with iALUZero = 1 → PC_en with PC_Select 01 in EX for BEQ; PC_en = 0 in EX for BNE.
- Opcode 0x3F → oHalt = 1 from the cycle after D, oIllegal = 0. Opcode 0x11 → oHalt = 1 and oIllegal = 1, held for 20 cycles.
- nRst pulsed low during an F wait → all outputs 0 asynchronously; RST, then FA on release.
- SW with iMemReady = 1 → oMemWrite high for 1 cycle in MW; oRF_Write never asserted.

Source files
------------

// File: rtl/proc_ctrl.sv
// proc_ctrl: multi-cycle fetch/decode/execute/memory/write-back control FSM.
// Outputs are decoded from state; only the EX branch PC enable also follows iALUZero.
module proc_ctrl (
  input  logic        iClk,
  input  logic        nRst,
  input  logic [31:0] iIR,
  input  logic        iALUZero,
  input  logic        iMemReady,
  output logic        oIR_en,
  output logic        oMDR_en,
  output logic        oMAR_en,
  output logic        oPC_en,
  output logic        oRF_Write,
  output logic        oMAR_Select,
  output logic        oALUsrcB_Select,
  output logic [1:0]  oPC_Select,
  output logic [1:0]  oRFC_Select,
  output logic [5:0]  oALU_op,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic        oHalt,
  output logic        oIllegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] ALU_ADD = 6'h20;
  localparam logic [5:0] ALU_SUB = 6'h22;
  localparam logic [5:0] ALU_AND = 6'h24;
  localparam logic [5:0] ALU_OR  = 6'h25;

  typedef enum logic [3:0] {
    S_RST, S_FA, S_F, S_D, S_EX, S_MA, S_MR, S_MW, S_WA, S_WM, S_HLT
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] alu_q, alu_d;
  logic       ill_q, ill_d;
  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic       unused_s;

  assign opcode_s = iIR[31:26];
  assign funct_s  = iIR[5:0];
  assign unused_s = ^iIR[25:6];

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_J, OP_HALT: is_legal = 1'b1;
      default:                       is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [5:0] alu_code(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      OP_RTYPE:                alu_code = funct;
      OP_ANDI:                 alu_code = ALU_AND;
      OP_ORI:                  alu_code = ALU_OR;
      OP_BEQ, OP_BNE:          alu_code = ALU_SUB;
      default:                 alu_code = ALU_ADD;
    endcase
  endfunction

  function automatic logic uses_imm(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: uses_imm = 1'b1;
      default:                                uses_imm = 1'b0;
    endcase
  endfunction

  // State, held ALU code and sticky illegal flag
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_RST;
      alu_q   <= 6'h00;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      ill_q   <= ill_d;
    end
  end

  // Next-state logic; the ALU code is captured on the way into EX so it holds afterwards
  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    ill_d   = ill_q;
    case (state_q)
      S_RST: state_d = S_FA;
      S_FA:  state_d = S_F;
      S_F: begin
        if (iMemReady) state_d = S_D;
        else           state_d = S_F;
      end
      S_D: begin
        if (opcode_s == OP_HALT) begin
          state_d = S_HLT;
        end else if (!is_legal(opcode_s)) begin
          state_d = S_HLT;
          ill_d   = 1'b1;
        end else begin
          state_d = S_EX;
          alu_d   = alu_code(opcode_s, funct_s);
        end
      end
      S_EX: begin
        case (opcode_s)
          OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI: state_d = S_WA;
          OP_LW, OP_SW:                       state_d = S_MA;
          default:                            state_d = S_FA;
        endcase
      end
      S_MA: begin
        if (opcode_s == OP_LW) state_d = S_MR;
        else                   state_d = S_MW;
      end
      S_MR: begin
        if (iMemReady) state_d = S_WM;
        else           state_d = S_MR;
      end
      S_MW: begin
        if (iMemReady) state_d = S_FA;
        else           state_d = S_MW;
      end
      S_WA, S_WM: state_d = S_FA;
      S_HLT:      state_d = S_HLT;
      default:    state_d = S_RST;
    endcase
  end

  // Datapath controls decoded from state
  always_comb begin
    oIR_en          = 1'b0;
    oMDR_en         = 1'b0;
    oMAR_en         = 1'b0;
    oPC_en          = 1'b0;
    oRF_Write       = 1'b0;
    oMAR_Select     = 1'b0;
    oALUsrcB_Select = 1'b0;
    oPC_Select      = 2'b00;
    oRFC_Select     = 2'b00;
    oALU_op         = alu_q;
    oMemRead        = 1'b0;
    oMemWrite       = 1'b0;
    oHalt           = 1'b0;
    oIllegal        = ill_q;
    case (state_q)
      S_FA: oMAR_en = 1'b1;
      S_F: begin
        oMemRead = 1'b1;
        if (iMemReady) begin
          oIR_en = 1'b1;
          oPC_en = 1'b1;
        end else begin
          oIR_en = 1'b0;
          oPC_en = 1'b0;
        end
      end
      S_EX: begin
        oALUsrcB_Select = uses_imm(opcode_s);
        case (opcode_s)
          OP_BEQ: begin
            oPC_en     = iALUZero;
            oPC_Select = 2'b01;
          end
          OP_BNE: begin
            oPC_en     = !iALUZero;
            oPC_Select = 2'b01;
          end
          OP_J: begin
            oPC_en     = 1'b1;
            oPC_Select = 2'b10;
          end
          default: oPC_Select = 2'b00;
        endcase
      end
      S_MA: begin
        oMAR_Select = 1'b1;
        oMAR_en     = 1'b1;
      end
      S_MR: begin
        oMemRead = 1'b1;
        if (iMemReady) oMDR_en = 1'b1;
        else           oMDR_en = 1'b0;
      end
      S_MW: oMemWrite = 1'b1;
      S_WA: oRF_Write = 1'b1;
      S_WM: begin
        oRF_Write   = 1'b1;
        oRFC_Select = 2'b01;
      end
      S_HLT:   oHalt = 1'b1;
      default: oHalt = 1'b0;
    endcase
  end

endmodule
